div_arbiter: RTL and testbench
==============================

Name: div_arbiter

Overview:
- Shares the single sequential divider between N requesters, e.g. the speed, average-speed and distance/time blocks of the bike computer.
- Round-robin arbitration: latches the winner's operands, drives the divider start/busy/ready handshake, and returns the quotient with a one-cycle per-requester done pulse.
- Sits between the measurement blocks and the divider instance in the top module.

Parameters:
- N, 4, number of requesters (2..8)
- WIDTH, 16, dividend/divisor/quotient width
- TIMEOUT, 64, cycles allowed in WAIT_BUSY or WAIT_READY before abort (DIV_TIMEOUT_EN only)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  N  request per requester; held high until its done pulse
- req_dividend  in  N*WIDTH  packed dividends, requester i at [i*WIDTH +: WIDTH]
- req_divisor  in  N*WIDTH  packed divisors, same packing
- gnt  out  N  one-hot, high while requester i owns the divider
- done  out  N  one-cycle pulse: result for requester i valid on res
- res  out  WIDTH  quotient, held until next done
- err  out  1  pulses with done when the result is invalid (divide-by-zero or timeout)
- div_start  out  1  one-cycle start strobe to divider
- div_dividend  out  WIDTH  registered operand
- div_divisor  out  WIDTH  registered operand
- div_busy  in  1  divider computing
- div_ready  in  1  divider quotient valid
- div_result  in  WIDTH  divider quotient

Behaviour:
- Reset values: gnt=0, done=0, res=0, err=0, div_start=0, div_dividend=0, div_divisor=0, state=IDLE, rr_ptr=0 (requester 0 has highest priority first).
- Reset mid-operation aborts the transaction. No done is issued; requesters re-request.
- Arbitration happens in IDLE only, when req!=0 and div_busy=0. Winner = first set req bit scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., N-1, 0, ...). On grant, rr_ptr <= winner+1 mod N. A requester is therefore never granted twice while another waits.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_READY, DONE.
- IDLE -> ISSUE on grant:
  - gnt[w] set.
  - div_dividend/div_divisor latched from slice w.
- ISSUE, normal path (divisor nonzero): div_start=1 for exactly this cycle -> WAIT_BUSY.
- ISSUE, divisor==0:
  - Divider is not started.
  - res <= all-ones, err=1 -> DONE.
- WAIT_BUSY: on div_busy=1 -> WAIT_READY. If div_ready=1 arrives in the same or an earlier cycle, also accept it (single-cycle divider): capture result and go to DONE.
- WAIT_READY: on div_ready=1, res <= div_result -> DONE.
- DONE, one cycle:
  - done[w]=1, gnt cleared.
  - Next state IDLE; the new arbitration decision takes effect the following cycle.
- Minimum latency, req to done: 4 cycles plus divider time. Back-to-back grants are separated by at least one IDLE cycle.
- req de-asserted by the owner mid-transaction is ignored; the transaction completes and done still pulses.
- Operands are sampled only at grant. Later changes on req_dividend/req_divisor do not affect the running divide.
- div_ready outside WAIT_BUSY/WAIT_READY is ignored.

Optional Feature:
- Macro: DIV_TIMEOUT_EN.
- Defined: a counter runs in WAIT_BUSY and WAIT_READY and resets on each state entry. Reaching TIMEOUT cycles forces DONE with res=all-ones, err=1, so a hung divider cannot lock out requesters.
- Undefined: no counter; the FSM waits indefinitely; the TIMEOUT parameter is unused.

Decomposition:
- Shared package div_pkg:
  - FSM state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_READY, DONE)
  - DIV_WIDTH default
  - DIV_ERR_VALUE (all-ones) constant
- One natural sub-module, rr_pick: purely combinational round-robin priority selector (req, rr_ptr -> one-hot winner, index, any).
- Everything else stays in div_arbiter.

Test Plan:
- Single request: req[1]=1, dividend=1000, divisor=8; divider model busy 16 cycles. Required:
  - div_start pulses once with 1000/8.
  - done[1] pulses with res=125, err=0; gnt[1] low afterwards.
- Fairness: req=4'b1111 held continuously with distinct operands. Required: grant order 0,1,2,3,0 and each done carries its own quotient.
- Divide-by-zero: req[2]=1, divisor=0. Required: div_start never asserted; done[2] pulses with res=16'hFFFF, err=1 on the cycle after ISSUE.
- Contention while busy: req[3] rises during requester 0's WAIT_READY. Required: gnt[3] no earlier than the cycle after done[0]; requester 0's operands unchanged on div_* throughout.
- Reset mid-operation: rst=1 in WAIT_READY. Required:
  - Next cycle all outputs are 0 and no done pulse is emitted.
  - A held request is re-granted after rst falls, starting from requester 0 priority.
- Timeout (DIV_TIMEOUT_EN, TIMEOUT=64): divider never raises div_ready. Required: done pulses 64 cycles after WAIT_READY entry with res=16'hFFFF, err=1; the next requester is served normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the divider arbiter: FSM state encoding and result constants.
// The optional hung-divider timeout is enabled with `define DIV_TIMEOUT_EN (see div_arbiter).
package div_pkg;

    localparam int DIV_WIDTH = 16;

    // Quotient reported for divide-by-zero and aborted transactions.
    localparam logic [DIV_WIDTH-1:0] DIV_ERR_VALUE = '1;

    typedef logic [2:0] div_state_t;

    localparam div_state_t ST_IDLE       = 3'd0;
    localparam div_state_t ST_ISSUE      = 3'd1;
    localparam div_state_t ST_WAIT_BUSY  = 3'd2;
    localparam div_state_t ST_WAIT_READY = 3'd3;
    localparam div_state_t ST_DONE       = 3'd4;

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit scanning upward from ptr with wrap.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any       = 1'b1;
                idx       = IW'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one sequential divider between N requesters.
// `define DIV_TIMEOUT_EN adds a TIMEOUT-cycle abort for a divider that never answers.
module div_arbiter
    import div_pkg::*;
#(
    parameter int N       = 4,
    parameter int WIDTH   = DIV_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] req_dividend,
    input  logic [N*WIDTH-1:0] req_divisor,
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       done,
    output logic [WIDTH-1:0]   res,
    output logic               err,
    output logic               div_start,
    output logic [WIDTH-1:0]   div_dividend,
    output logic [WIDTH-1:0]   div_divisor,
    input  logic               div_busy,
    input  logic               div_ready,
    input  logic [WIDTH-1:0]   div_result,
    output div_state_t         dbg_state
);

    // Handshake: a requester holds req until its one-cycle done pulse; toward the
    // divider, div_start is a single-cycle strobe, div_busy means computing, and
    // div_result is taken only on a div_ready cycle while waiting for that result.

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] ERR_VALUE = {WIDTH{1'b1}};

    if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("div_arbiter: N must be 2..8 and TIMEOUT >= 1");
    end

    div_state_t    state, state_n;
    logic [IW-1:0] rr_ptr;
    logic [N-1:0]  pick_oh;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [WIDTH-1:0] sel_dividend, sel_divisor;
    logic          finish_err;
    logic          tmo_hit;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign sel_dividend = req_dividend[int'(pick_idx)*WIDTH +: WIDTH];
    assign sel_divisor  = req_divisor[int'(pick_idx)*WIDTH +: WIDTH];
    assign dbg_state    = state;

`ifdef DIV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    // Restarts on every state change, so each wait state gets its own budget.
    always_ff @(posedge clk) begin
        if (rst || state_n != state) begin
            tmo_cnt <= '0;
        end else if (state == ST_WAIT_BUSY || state == ST_WAIT_READY) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        finish_err = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any && !div_busy) state_n = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (div_divisor == '0) begin
                    state_n    = ST_DONE;
                    finish_err = 1'b1;
                end else begin
                    state_n = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                // A single-cycle divider may answer before busy is ever seen.
                if (div_ready) begin
                    state_n = ST_DONE;
                end else if (div_busy) begin
                    state_n = ST_WAIT_READY;
                end else if (tmo_hit) begin
                    state_n    = ST_DONE;
                    finish_err = 1'b1;
                end
            end
            ST_WAIT_READY: begin
                if (div_ready) begin
                    state_n = ST_DONE;
                end else if (tmo_hit) begin
                    state_n    = ST_DONE;
                    finish_err = 1'b1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            gnt          <= '0;
            done         <= '0;
            res          <= '0;
            err          <= 1'b0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            state     <= state_n;
            done      <= '0;
            err       <= 1'b0;
            div_start <= 1'b0;
            if (state == ST_IDLE && state_n == ST_ISSUE) begin
                gnt          <= pick_oh;
                div_dividend <= sel_dividend;
                div_divisor  <= sel_divisor;
                div_start    <= (sel_divisor != '0);
                rr_ptr       <= (int'(pick_idx) == N - 1) ? '0 : pick_idx + 1'b1;
            end
            if (state != ST_DONE && state_n == ST_DONE) begin
                done <= gnt;
                gnt  <= '0;
                err  <= finish_err;
                res  <= finish_err ? ERR_VALUE : div_result;
            end
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural sequential divider model.
// Build with +define+DIV_TIMEOUT_EN (on both bench and RTL) to include the timeout scenario.
module tb_div_arbiter;
  import div_pkg::*;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int EW = 3 + 1 + W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req, gnt, done;
  logic [N*W-1:0] req_dividend, req_divisor;
  logic [W-1:0] res, div_dividend, div_divisor;
  logic [W-1:0] div_result = '0;
  logic err, div_start;
  logic div_busy = 1'b0;
  logic div_ready = 1'b0;
  div_state_t dbg_state;

  div_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .gnt          (gnt),
    .done         (done),
    .res          (res),
    .err          (err),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_busy     (div_busy),
    .div_ready    (div_ready),
    .div_result   (div_result),
    .dbg_state    (dbg_state)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  // requesters: req[i] is high while issued[i] outruns served[i]
  int issued[N] = '{default: 0};
  int served[N] = '{default: 0};
  logic [W-1:0] dd[N] = '{default: '0};
  logic [W-1:0] dv[N] = '{default: '0};

  always_comb begin
    req          = '0;
    req_dividend = '0;
    req_divisor  = '0;
    for (int i = 0; i < N; i++) begin
      req[i]               = (issued[i] != served[i]);
      req_dividend[i*W +: W] = dd[i];
      req_divisor[i*W +: W]  = dv[i];
    end
  end

  // divider model: busy for lat cycles after start, then one-cycle ready
  int lat = 4;
  bit hang = 1'b0;
  int m_cnt = 0;
  logic [W-1:0] m_q = '0;

  always @(negedge clk) begin
    div_ready = 1'b0;
    if (rst) begin
      div_busy = 1'b0;
      m_cnt    = 0;
    end else if (div_start) begin
      div_busy = 1'b1;
      m_cnt    = lat;
      m_q      = (div_divisor == '0) ? '1 : div_dividend / div_divisor;
    end else if (div_busy && !hang) begin
      if (m_cnt <= 1) begin
        div_busy   = 1'b0;
        div_ready  = 1'b1;
        div_result = m_q;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor
  int start_cnt = 0;
  logic [2*W-1:0] start_ops = '0;
  int last_issue_cyc = 0, last_done_cyc = 0, wr_entry_cyc = 0;
  int gnt_cyc[N] = '{default: 0};
  int done_cyc[N] = '{default: 0};
  int gnt_log[$];
  logic [N-1:0] prev_gnt = '0;
  div_state_t prev_state = ST_IDLE;
  logic [2:0] m_idx;
  logic [EW-1:0] m_got;

  always @(negedge clk) begin
    if (div_start) begin
      start_cnt++;
      start_ops = {div_dividend, div_divisor};
    end
    if (dbg_state == ST_ISSUE) last_issue_cyc = cyc;
    if (dbg_state == ST_WAIT_READY && prev_state != ST_WAIT_READY) wr_entry_cyc = cyc;
    prev_state = dbg_state;
    if (gnt != prev_gnt && gnt != '0) begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) begin
          gnt_log.push_back(i);
          gnt_cyc[i] = cyc;
        end
      end
    end
    prev_gnt = gnt;
    if (done != '0) begin
      m_idx = 3'd7;
      if ($onehot(done)) begin
        for (int i = 0; i < N; i++) if (done[i]) m_idx = 3'(i);
      end
      m_got = {m_idx, err, res};
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done: got {idx,err,res}=0x%0h, expected no done", m_got);
      end else begin
        check("done_result", 64'(m_got), 64'(exp_q.pop_front()));
      end
      if (m_idx < 3'(N)) begin
        served[m_idx]++;
        done_cyc[m_idx] = cyc;
      end
      last_done_cyc = cyc;
    end
  end

  // driver tasks
  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic e);
    dd[i] = a;
    dv[i] = b;
    exp_q.push_back({3'(i), e, q});
    issued[i]++;
  endtask

  task automatic wait_empty(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL wait_done: %0d results pending after %0d cycles, expected 0", exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_state(input div_state_t s, input int budget);
    int k = 0;
    while (dbg_state != s && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (dbg_state != s) begin
      n_vec++;
      n_miss++;
      $display("FAIL wait_state: state %0d after %0d cycles, expected %0d", dbg_state, budget, s);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int s0, st0, k;
  bit bad;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", 64'({gnt, done, res, err, div_start, div_dividend, div_divisor, dbg_state}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // single request, 16-cycle divider
    lat = 16;
    issue(1, 16'd1000, 16'd8, 16'd125, 1'b0);
    wait_empty(100);
    check("t1_start_count", 64'(start_cnt), 64'd1);
    check("t1_start_ops", 64'(start_ops), 64'({16'd1000, 16'd8}));
    check("t1_gnt_low", 64'(gnt), 64'd0);

    // fairness from a fresh pointer
    do_reset();
    gnt_log.delete();
    lat = 3;
    issue(0, 16'd100, 16'd10, 16'd10, 1'b0);
    issue(1, 16'd500, 16'd7, 16'd71, 1'b0);
    issue(2, 16'd65535, 16'd255, 16'd257, 1'b0);
    issue(3, 16'd9, 16'd3, 16'd3, 1'b0);
    issue(0, 16'd100, 16'd10, 16'd10, 1'b0);
    wait_empty(200);
    check("t2_grant_count", 64'(gnt_log.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < gnt_log.size()) check("t2_grant_order", 64'(gnt_log[i]), 64'(exp_order[i]));
    end

    // divide by zero
    st0 = start_cnt;
    issue(2, 16'd1234, 16'd0, 16'hFFFF, 1'b1);
    wait_empty(50);
    check("t3_no_start", 64'(start_cnt - st0), 64'd0);
    check("t3_done_after_issue", 64'(last_done_cyc - last_issue_cyc), 64'd1);

    // contention while busy; owner's operands change after grant
    lat = 20;
    issue(0, 16'd4000, 16'd16, 16'd250, 1'b0);
    wait_state(ST_WAIT_READY, 50);
    issue(3, 16'd300, 16'd4, 16'd75, 1'b0);
    dd[0] = 16'd9999;
    bad = 1'b0;
    k = 0;
    s0 = served[0];
    while (served[0] == s0 && k < 100) begin
      if (div_dividend !== 16'd4000 || div_divisor !== 16'd16) bad = 1'b1;
      @(negedge clk);
      k++;
    end
    check("t4_operands_stable", 64'(bad), 64'd0);
    wait_empty(100);
    check("t4_gnt3_after_done0", 64'(gnt_cyc[3] >= done_cyc[0] + 1), 64'd1);

    // reset in WAIT_READY; pending r1 must win over r3 again afterwards
    lat = 30;
    issue(1, 16'd800, 16'd4, 16'd200, 1'b0);
    wait_state(ST_WAIT_READY, 50);
    issue(3, 16'd77, 16'd7, 16'd11, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t5_reset_outputs", 64'({gnt, done, res, err, div_start, div_dividend, div_divisor, dbg_state}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_empty(200);

`ifdef DIV_TIMEOUT_EN
    // hung divider
    lat = 1;
    hang = 1'b1;
    issue(0, 16'd5, 16'd1, DIV_ERR_VALUE, 1'b1);
    wait_empty(200);
    check("t6_timeout_latency", 64'(last_done_cyc - wr_entry_cyc), 64'd64);
    hang = 1'b0;
    issue(1, 16'd50, 16'd5, 16'd10, 1'b0);
    wait_empty(100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
